// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
//   Shared types and constants for the run_ctrl program loader.
//   - state_t   : loader/run sequencing states
//   - byte_t    : one byte of the incoming program stream
//   - word_t    : one 32-bit instruction-memory word
//   - HALT_WORD : halt instruction word, also used in the bench program image
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  localparam word_t HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/run_ctrl_byte_packer.sv
// byte_packer
//   Packs an 8-bit byte stream into little-endian 32-bit words. The first
//   byte of each group of four lands in bits 7:0. word_valid pulses for one
//   cycle, the cycle after the fourth byte is taken. Gaps in in_valid simply
//   stall the assembly; the partial word is kept until clear or reset.
// Ports
//   clk, rst_n  : clock, async active-low reset
//   clear       : synchronous discard of any partial word
//   in_valid    : in_byte is consumed this cycle
//   in_byte     : stream byte
//   word        : last completed word (held until the next one completes)
//   word_valid  : one-cycle strobe, word is new
module byte_packer
  import run_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_idx;
  logic [23:0] partial;
  word_t       word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= 2'd0;
      partial    <= 24'd0;
      word_q     <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= 2'd0;
      end else if (in_valid) begin
        // Shift right so earlier bytes end up in the low lanes.
        if (byte_idx == 2'd3) begin
          word_q     <= {in_byte, partial};
          word_valid <= 1'b1;
        end else begin
          partial <= {in_byte, partial[23:8]};
        end
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  assign word = word_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl
//   Receives a program over a byte stream (16-bit little-endian word count,
//   then count*4 bytes), writes it to instruction memory starting at
//   START_ADDR, releases the CPU from reset and waits for its halt.
//   Optional feature macro: RUN_CTRL_CYCLE_CNT_EN enables the run-cycle
//   counter on 'cycles'; without it 'cycles' is tied to 0.
// Ports
//   CLOCK_50, RSTN_N      : clock, async active-low reset
//   rx_data/valid/ready   : program byte stream, accepted on valid&&ready
//   imem_we/addr/wdata    : instruction-memory write port
//   cpu_rstn_n            : active-low reset to the CPU
//   cpu_halt_n            : active-low halt from the CPU
//   busy, done, err       : status (err is a one-cycle pulse on a bad header)
//   cycles                : CPU run-cycle count
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for word-count low byte, CPU held in reset
// HDR     | waiting for word-count high byte, header validated here
// LOAD    | packing bytes into words and writing instruction memory
// RUN     | CPU released, counting cycles until halt is seen
// DONE    | CPU halted but kept out of reset; next byte starts a reload
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 4
) (
  input  logic              CLOCK_50,
  input  logic              RSTN_N,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn_n,
  input  logic              cpu_halt_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       cycles
);

  localparam logic [31:0] MAX_WORDS = 32'((2 ** ADDR_W) - START_ADDR);

  state_t      state;
  byte_t       n_lo;
  byte_t       n_hi;
  logic [15:0] word_idx;
  logic [15:0] hdr_n;
  logic        rx_acc;
  logic        start_acc;
  logic        hdr_bad;
  logic        last_strobe;
  logic        pk_feed;
  logic        pk_clear;
  logic        pk_word_valid;
  word_t       pk_word;

  assign rx_ready  = (state != ST_RUN);
  assign rx_acc    = rx_valid && rx_ready;
  assign start_acc = rx_acc && ((state == ST_IDLE) || (state == ST_DONE));

  assign hdr_n   = {rx_data, n_lo};
  assign hdr_bad = (hdr_n == 16'd0) || (32'(hdr_n) > MAX_WORDS);

  // The strobe of the final word is the only cycle in LOAD where a byte
  // could be accepted but must not start another word.
  assign last_strobe = pk_word_valid && (word_idx == ({n_hi, n_lo} - 16'd1));
  assign pk_feed     = rx_valid && (state == ST_LOAD) && !last_strobe;
  assign pk_clear    = start_acc;

  byte_packer u_packer (
    .clk        (CLOCK_50),
    .rst_n      (RSTN_N),
    .clear      (pk_clear),
    .in_valid   (pk_feed),
    .in_byte    (rx_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  assign imem_we    = pk_word_valid;
  assign imem_wdata = pk_word;

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      state      <= ST_IDLE;
      n_lo       <= '0;
      n_hi       <= '0;
      word_idx   <= '0;
      imem_addr  <= '0;
      cpu_rstn_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      // imem_addr tracks the word being assembled, so it already holds the
      // right address during the strobe and steps right after it.
      if (pk_word_valid) begin
        imem_addr <= imem_addr + ADDR_W'(1);
        word_idx  <= word_idx + 16'd1;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_acc) begin
            n_lo       <= rx_data;
            state      <= ST_HDR;
            busy       <= 1'b1;
            done       <= 1'b0;
            cpu_rstn_n <= 1'b0;
          end
        end
        ST_HDR: begin
          if (rx_acc) begin
            if (hdr_bad) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              n_hi      <= rx_data;
              word_idx  <= 16'd0;
              imem_addr <= ADDR_W'(START_ADDR);
              state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (last_strobe) begin
            cpu_rstn_n <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!cpu_halt_n) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          cpu_rstn_n <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  // Counts every RUN cycle including the one where halt is sampled; wraps
  // naturally and holds through DONE until a new program starts.
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      cycle_cnt <= 32'd0;
    end else if (start_acc) begin
      cycle_cnt <= 32'd0;
    end else if (state == ST_RUN) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign cycles = cycle_cnt;
`else
  assign cycles = 32'd0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  logic        CLOCK_50;
  logic        RSTN_N;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rstn_n;
  logic        cpu_halt_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

`ifdef RUN_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  run_ctrl #(.ADDR_W(8), .START_ADDR(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .RSTN_N     (RSTN_N),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rstn_n (cpu_rstn_n),
    .cpu_halt_n (cpu_halt_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cycles     (cycles)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (RSTN_N && imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [31:0] wq_addr(input int i);
    return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wq_data(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    RSTN_N     = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    cpu_halt_n = 1'b1;
    step(3);
    chk("rst_cpu_rstn", 32'(cpu_rstn_n), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd1);
    RSTN_N = 1'b1;
    step(1);

    // Zero-length header is rejected.
    send_byte(8'h00);
    chk("hdr0_busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    rx_valid = 1'b0;
    chk("hdr0_err", 32'(err), 32'd1);
    chk("hdr0_busy_off", 32'(busy), 32'd0);
    step(1);
    chk("hdr0_err_pulse", 32'(err), 32'd0);
    chk("hdr0_no_write", 32'(wr_addr.size()), 32'd0);

    // Two-word program, back to back.
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("w0_we", 32'(imem_we), 32'd1);
    chk("w0_addr", 32'(imem_addr), 32'd4);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    rx_valid = 1'b0;
    chk("w1_we", 32'(imem_we), 32'd1);
    chk("w1_addr", 32'(imem_addr), 32'd5);
    chk("w1_data", imem_wdata, 32'hDDCCBBAA);
    chk("load_cpu_rst", 32'(cpu_rstn_n), 32'd0);
    step(1);
    chk("run_cpu_rstn", 32'(cpu_rstn_n), 32'd1);
    chk("run_ready", 32'(rx_ready), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_we_off", 32'(imem_we), 32'd0);
    chk("p1_nwr", 32'(wr_addr.size()), 32'd2);
    chk("p1_a0", wq_addr(0), 32'd4);
    chk("p1_d0", wq_data(0), 32'h44332211);
    chk("p1_a1", wq_addr(1), 32'd5);
    chk("p1_d1", wq_data(1), 32'hDDCCBBAA);
    cpu_halt_n = 1'b0;
    step(1);
    cpu_halt_n = 1'b1;
    chk("p1_done", 32'(done), 32'd1);
    chk("p1_busy", 32'(busy), 32'd0);
    chk("p1_done_cpu_rstn", 32'(cpu_rstn_n), 32'd1);
    chk("p1_cycles", cycles, CNT_EN ? 32'd1 : 32'd0);
    step(2);
    chk("p1_done_hold", 32'(done), 32'd1);
    chk("p1_cycles_hold", cycles, CNT_EN ? 32'd1 : 32'd0);

    // Restart from DONE, three words, gapped stream, halt word last.
    send_byte(8'h03);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cycles", cycles, 32'd0);
    chk("restart_cpu_rstn", 32'(cpu_rstn_n), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h55); send_byte(8'h66);
    rx_valid = 1'b0;
    step(5);
    chk("gap_we", 32'(imem_we), 32'd0);
    chk("gap_nwr", 32'(wr_addr.size()), 32'd3);
    send_byte(8'h77); send_byte(8'h88);
    send_byte(HALT_WORD[7:0]);   send_byte(HALT_WORD[15:8]);
    send_byte(HALT_WORD[23:16]); send_byte(HALT_WORD[31:24]);
    rx_valid = 1'b0;
    step(1);
    chk("p2_cpu_rstn", 32'(cpu_rstn_n), 32'd1);
    chk("p2_nwr", 32'(wr_addr.size()), 32'd5);
    chk("p2_a0", wq_addr(2), 32'd4);
    chk("p2_d0", wq_data(2), 32'h04030201);
    chk("p2_a1", wq_addr(3), 32'd5);
    chk("p2_d1", wq_data(3), 32'h88776655);
    chk("p2_a2", wq_addr(4), 32'd6);
    chk("p2_d2", wq_data(4), HALT_WORD);
    step(9);
    chk("p2_not_done", 32'(done), 32'd0);
    cpu_halt_n = 1'b0;
    step(1);
    cpu_halt_n = 1'b1;
    chk("p2_done", 32'(done), 32'd1);
    chk("p2_cycles", cycles, CNT_EN ? 32'd10 : 32'd0);

    // Reset mid-LOAD drops the partial word.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b0;
    chk("midload_busy", 32'(busy), 32'd1);
    #4;
    RSTN_N = 1'b0;
    #1;
    chk("midload_rst_cpu", 32'(cpu_rstn_n), 32'd0);
    chk("midload_rst_busy", 32'(busy), 32'd0);
    chk("midload_rst_done", 32'(done), 32'd0);
    step(1);
    RSTN_N = 1'b1;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    rx_valid = 1'b0;
    chk("reload_we", 32'(imem_we), 32'd1);
    chk("reload_addr", 32'(imem_addr), 32'd4);
    chk("reload_data", imem_wdata, 32'hDDCCBBAA);
    step(1);
    chk("reload_run", 32'(cpu_rstn_n), 32'd1);
    step(2);

    // Reset while running.
    #3;
    RSTN_N = 1'b0;
    #1;
    chk("runrst_cpu", 32'(cpu_rstn_n), 32'd0);
    chk("runrst_cycles", cycles, 32'd0);
    chk("runrst_ready", 32'(rx_ready), 32'd1);
    chk("p3_nwr", 32'(wr_addr.size()), 32'd6);
    step(1);
    RSTN_N = 1'b1;

    // Header range limits: 2**8-4 = 252 words.
    send_byte(8'hFD);
    send_byte(8'h00);
    rx_valid = 1'b0;
    chk("n253_err", 32'(err), 32'd1);
    step(1);
    send_byte(8'hFC);
    send_byte(8'h00);
    rx_valid = 1'b0;
    chk("n252_err", 32'(err), 32'd0);
    chk("n252_busy", 32'(busy), 32'd1);
    chk("n252_addr", 32'(imem_addr), 32'd4);
    RSTN_N = 1'b0;
    step(1);
    RSTN_N = 1'b1;
    send_byte(8'h00);
    send_byte(8'h01);
    rx_valid = 1'b0;
    chk("n256_err", 32'(err), 32'd1);
    step(1);
    chk("n256_idle", 32'(busy), 32'd0);
    chk("final_nwr", 32'(wr_addr.size()), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter START_ADDR, default 4, first word address written by the loader.
REQ-003 SHALL have port CLOCK_50  in  1  sole clock, rising edge.
REQ-004 SHALL have port RSTN_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  in  8  program byte stream.
REQ-006 SHALL have port rx_valid  in  1  rx_data valid.
REQ-007 SHALL have port rx_ready  out  1  byte accepted when rx_valid&&rx_ready at a rising edge.
REQ-008 SHALL have port imem_we  out  1  instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  out  ADDR_W  write word address.
REQ-010 SHALL have port imem_wdata  out  32  write data.
REQ-011 SHALL have port cpu_rstn_n  out  1  active-low reset driven to the CPU.
REQ-012 SHALL have port cpu_halt_n  in  1  active-low halt from the CPU.
REQ-013 SHALL have port busy  out  1  high in HDR, LOAD or RUN.
REQ-014 SHALL have port done  out  1  high in DONE.
REQ-015 SHALL have port err  out  1  one-cycle error pulse.
REQ-016 SHALL have port cycles  out  32  CPU run-cycle count.

Function
REQ-017 SHALL implement states IDLE, HDR, LOAD, RUN, DONE.
REQ-018 rx_ready SHALL be 1 in IDLE, HDR, LOAD and DONE, and 0 in RUN.
REQ-019 IDLE/DONE: accepted byte = word-count low byte; clear done and cycles; go HDR.
REQ-020 HDR: accepted byte = count high byte; N = 16-bit little-endian count.
REQ-021 N==0 or N > 2**ADDR_W-START_ADDR SHALL pulse err for one cycle and return to IDLE; no memory write.
REQ-022 LOAD: each 4 accepted bytes SHALL form one word, first byte = bits 7:0 (little-endian).
REQ-023 For word k, imem_we SHALL pulse high exactly one cycle, the cycle after the 4th byte is accepted, with imem_addr=START_ADDR+k.
REQ-024 LOAD SHALL accept back-to-back bytes every cycle with no bubbles.
REQ-025 After the strobe for word N-1, the next state SHALL be RUN; cpu_rstn_n SHALL be 1 from the first RUN cycle.
REQ-026 cpu_rstn_n SHALL be 0 in every state except RUN and DONE.
REQ-027 RUN: cpu_halt_n sampled 0 SHALL move the block to DONE on the next edge.
REQ-028 DONE SHALL keep cpu_rstn_n=1 so CPU state stays observable.
REQ-029 DONE: done=1 until a byte is accepted.
REQ-030 A byte accepted in DONE SHALL be taken per REQ-019 and SHALL drive cpu_rstn_n to 0 on the same edge.
REQ-031 cycles SHALL increment by 1 each RUN cycle, including the cycle in which halt is sampled.
REQ-032 cycles SHALL hold its value in DONE and wrap modulo 2**32.
REQ-033 rx_valid deasserting mid-word SHALL stall the assembler and keep the partial word.

Reset
REQ-034 RSTN_N low SHALL asynchronously force IDLE, discard any partial word and zero the word index.
REQ-035 RSTN_N low SHALL force cpu_rstn_n=0, imem_we=0, busy=0, done=0, err=0 and cycles=0.
REQ-036 Reset asserted in RUN SHALL still force cpu_rstn_n=0 immediately.
REQ-037 imem_addr and imem_wdata SHALL reset to 0.

Configuration
REQ-038 With RUN_CTRL_CYCLE_CNT_EN defined, the cycles counter SHALL be implemented per REQ-031 and REQ-032.
REQ-039 Without RUN_CTRL_CYCLE_CNT_EN, cycles SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-040 Package run_ctrl_pkg SHALL hold the state enum, byte/word typedefs and HALT_WORD=32'hFFFF_FFFF, the constant shared with the bench program image.
REQ-041 Byte-to-word assembly SHALL be the sub-module byte_packer (8-bit in, 32-bit word plus one-cycle word_valid out).

Verification
REQ-042 Stream 02 00, 11 22 33 44, AA BB CC DD -> writes 0x44332211@4 and 0xDDCCBBAA@5, then cpu_rstn_n rises.
REQ-043 Header 00 00 -> err one cycle, state IDLE, imem_we never asserted.
REQ-044 N=3, cpu_halt_n driven low 10 cycles after RUN entry -> done=1, cycles=10 (0 without the macro).
REQ-045 rx_valid gapped after byte 2 for 5 cycles -> word still correct, single imem_we.
REQ-046 RSTN_N pulsed low mid-LOAD -> cpu_rstn_n=0 at once; fresh header reloads from address 4.
REQ-047 New header byte in DONE -> done=0, cycles=0 and cpu_rstn_n=0 on the same edge.
